// File: rtl/wiegand_tx_ctrl_if.sv
// Register-file side of the Wiegand transmitter: request pulses in, status and line drive out.
// start/abort/int_ack are single-cycle pulses sampled on clk; there is no back-pressure, start is taken only when idle.
interface wiegand_tx_ctrl_if #(
    parameter int FRAME_BITS = 26
);
    logic                  start;
    logic                  abort;
    logic [FRAME_BITS-1:0] frame_data;
    logic [2:0]            chan_en;
    logic                  int_ack;
    logic                  busy;
    logic                  done_n;
    logic [4:0]            bit_idx;
    logic [1:0]            wil_out0;
    logic [1:0]            wil_out1;
    logic [1:0]            wil_out2;
    logic [1:0]            fsm_state;

    modport master (
        output start, abort, frame_data, chan_en, int_ack,
        input  busy, done_n, bit_idx, wil_out0, wil_out1, wil_out2, fsm_state
    );

    modport slave (
        input  start, abort, frame_data, chan_en, int_ack,
        output busy, done_n, bit_idx, wil_out0, wil_out1, wil_out2, fsm_state
    );
endinterface

// File: rtl/wiegand_tx_ctrl.sv
// Serializes a latched Wiegand frame MSB-first onto up to three D0/D1 line pairs,
// then holds an idle gap before raising the active-low completion interrupt.
module wiegand_tx_ctrl #(
    parameter int FRAME_BITS = 26,
    parameter int PULSE_CYC  = 100,
    parameter int PERIOD_CYC = 2000,
    parameter int GAP_CYC    = 10000
) (
    input logic               clk,
    input logic               nReset,
    wiegand_tx_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, SPACE = 2'd2, GAP = 2'd3} state_t;

    localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
    localparam logic [15:0] SPACE_LD = 16'(PERIOD_CYC - PULSE_CYC - 1);
    localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);
    localparam logic [4:0]  IDX_TOP  = 5'(FRAME_BITS - 1);

    state_t                state, state_nx;
    logic [15:0]           cnt, cnt_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx;
    logic [2:0]            mask, mask_nx;
    logic [4:0]            idx, idx_nx;
    logic                  busy_r, busy_nx;
    logic                  done_r, done_nx;
    logic [1:0]            line_nx;
    logic [1:0]            out0_r, out1_r, out2_r;
    logic [1:0]            out0_nx, out1_nx, out2_nx;

    // A one bit pulls D1 low, a zero pulls D0 low; never both.
    function automatic logic [1:0] enc(input logic b);
        return b ? 2'b01 : 2'b10;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        mask_nx  = mask;
        idx_nx   = idx;
        busy_nx  = busy_r;
        done_nx  = done_r | bus.int_ack;
        line_nx  = 2'b11;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort && bus.chan_en != 3'b000) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                    shreg_nx = bus.frame_data;
                    mask_nx  = bus.chan_en;
                    idx_nx   = IDX_TOP;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b1;
                    line_nx  = enc(bus.frame_data[FRAME_BITS-1]);
                end
            end
            PULSE: begin
                if (cnt == 16'd0) begin
                    state_nx = SPACE;
                    cnt_nx   = SPACE_LD;
                end else begin
                    cnt_nx  = cnt - 16'd1;
                    line_nx = enc(shreg[FRAME_BITS-1]);
                end
            end
            SPACE: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else if (idx != 5'd0) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                    idx_nx   = idx - 5'd1;
                    shreg_nx = {shreg[FRAME_BITS-2:0], 1'b0};
                    line_nx  = enc(shreg[FRAME_BITS-2]);
                end else begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt == 16'd0) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b0;
                    idx_nx   = 5'd0;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort drops the frame without signalling completion, even on the last gap cycle.
        if (state != IDLE && bus.abort) begin
            state_nx = IDLE;
            cnt_nx   = 16'd0;
            busy_nx  = 1'b0;
            idx_nx   = 5'd0;
            done_nx  = done_r | bus.int_ack;
            line_nx  = 2'b11;
        end

        out0_nx = mask_nx[0] ? line_nx : 2'b11;
        out1_nx = mask_nx[1] ? line_nx : 2'b11;
        out2_nx = mask_nx[2] ? line_nx : 2'b11;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            shreg  <= '0;
            mask   <= 3'b000;
            idx    <= 5'd0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            out0_r <= 2'b11;
            out1_r <= 2'b11;
            out2_r <= 2'b11;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            shreg  <= shreg_nx;
            mask   <= mask_nx;
            idx    <= idx_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            out0_r <= out0_nx;
            out1_r <= out1_nx;
            out2_r <= out2_nx;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done_n    = done_r;
    assign bus.bit_idx   = idx;
    assign bus.wil_out0  = out0_r;
    assign bus.wil_out1  = out1_r;
    assign bus.wil_out2  = out2_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_wiegand_tx_ctrl.sv
// Bench for wiegand_tx_ctrl with shortened timing; a line decoder checks every pulse against the expected queue.
module tb_wiegand_tx_ctrl;
    localparam int FB        = 26;
    localparam int P_PULSE   = 5;
    localparam int P_PERIOD  = 20;
    localparam int P_GAP     = 60;
    localparam int FRAME_LEN = FB * P_PERIOD + P_GAP;
    localparam int W         = 32;
    localparam logic [12:0] IDLE_V = {2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 5'd0};

    typedef struct {
        int          rel;
        logic [12:0] v;
    } vec_t;

    logic clk = 1'b0;
    logic nReset = 1'b0;

    wiegand_tx_ctrl_if #(.FRAME_BITS(FB)) bus ();

    wiegand_tx_ctrl #(
        .FRAME_BITS(FB),
        .PULSE_CYC (P_PULSE),
        .PERIOD_CYC(P_PERIOD),
        .GAP_CYC   (P_GAP)
    ) dut (
        .clk   (clk),
        .nReset(nReset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int t_start = 0;
    int done_cnt = 0;
    logic [W-1:0]  exp_q[$];
    logic [1:0]    prev_l [3] = '{2'b11, 2'b11, 2'b11};
    logic          prev_done = 1'b1;
    logic [FB-1:0] rx [3];
    vec_t          tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, want, ncyc);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.wil_out0, bus.wil_out1, bus.wil_out2, bus.busy, bus.done_n, bus.bit_idx};
    endfunction

    function automatic logic [12:0] mk(input logic [1:0] o0, input logic b, input logic dn, input logic [4:0] ix);
        return {o0, 2'b11, 2'b11, b, dn, ix};
    endfunction

    // Loopback receiver: decodes each falling pulse and scores it against the expected queue.
    task automatic monitor_step();
        logic [1:0] cur;
        logic       b;
        ncyc++;
        for (int ch = 0; ch < 3; ch++) begin
            cur = (ch == 0) ? bus.wil_out0 : (ch == 1) ? bus.wil_out1 : bus.wil_out2;
            check("lines_not_00", {31'd0, cur == 2'b00}, 32'd0);
            if (prev_l[ch] == 2'b11 && cur != 2'b11) begin
                b = (cur == 2'b01);
                rx[ch] = {rx[ch][FB-2:0], b};
                if (exp_q.size() == 0)
                    check("unexpected_pulse", {2'(ch), b, 29'(ncyc - t_start)}, 32'hFFFF_FFFF);
                else
                    check("pulse", {2'(ch), b, 29'(ncyc - t_start)}, exp_q.pop_front());
            end
            prev_l[ch] = cur;
        end
        if (prev_done === 1'b1 && bus.done_n === 1'b0) done_cnt++;
        prev_done = bus.done_n;
    endtask

    always @(negedge clk) monitor_step();

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go_to(input int r);
        while (ncyc - t_start < r) tick();
    endtask

    // Drives a start for one cycle and queues the pulses expected up to cycle 'cut' (0 = whole frame).
    task automatic send_frame(input logic [FB-1:0] d, input logic [2:0] m, input int cut);
        bus.frame_data = d;
        bus.chan_en    = m;
        bus.start      = 1'b1;
        t_start        = ncyc;
        for (int k = FB - 1; k >= 0; k--) begin
            int rel;
            rel = 1 + (FB - 1 - k) * P_PERIOD;
            if (cut == 0 || rel <= cut)
                for (int ch = 0; ch < 3; ch++)
                    if (m[ch]) exp_q.push_back({2'(ch), d[k], 29'(rel)});
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < FRAME_LEN + 20 && !(ncyc - t_start > 1 && bus.busy === 1'b0)) begin
            tick();
            n++;
        end
        check({name, "_end_cycle"}, 32'(ncyc - t_start), 32'(FRAME_LEN + 1));
        check({name, "_done_n"}, {31'd0, bus.done_n}, 32'd0);
    endtask

    task automatic ack(input string name);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check({name, "_ack"}, {31'd0, bus.done_n}, 32'd1);
    endtask

    initial begin
        logic [FB-1:0] d;
        logic [2:0]    m;

        tbl[0]  = '{1,                          mk(2'b01, 1'b1, 1'b1, 5'd25)};
        tbl[1]  = '{P_PULSE,                    mk(2'b01, 1'b1, 1'b1, 5'd25)};
        tbl[2]  = '{P_PULSE + 1,                mk(2'b11, 1'b1, 1'b1, 5'd25)};
        tbl[3]  = '{P_PERIOD,                   mk(2'b11, 1'b1, 1'b1, 5'd25)};
        tbl[4]  = '{P_PERIOD + 1,               mk(2'b10, 1'b1, 1'b1, 5'd24)};
        tbl[5]  = '{P_PERIOD + P_PULSE,         mk(2'b10, 1'b1, 1'b1, 5'd24)};
        tbl[6]  = '{P_PERIOD + P_PULSE + 1,     mk(2'b11, 1'b1, 1'b1, 5'd24)};
        tbl[7]  = '{2 * P_PERIOD + 1,           mk(2'b01, 1'b1, 1'b1, 5'd23)};
        tbl[8]  = '{25 * P_PERIOD + 1,          mk(2'b10, 1'b1, 1'b1, 5'd0)};
        tbl[9]  = '{25 * P_PERIOD + P_PULSE,    mk(2'b10, 1'b1, 1'b1, 5'd0)};
        tbl[10] = '{25 * P_PERIOD + P_PULSE + 1, mk(2'b11, 1'b1, 1'b1, 5'd0)};
        tbl[11] = '{26 * P_PERIOD + 1,          mk(2'b11, 1'b1, 1'b1, 5'd0)};
        tbl[12] = '{FRAME_LEN,                  mk(2'b11, 1'b1, 1'b1, 5'd0)};
        tbl[13] = '{FRAME_LEN + 1,              mk(2'b11, 1'b0, 1'b0, 5'd0)};
        tbl[14] = '{FRAME_LEN + 10,             mk(2'b11, 1'b0, 1'b0, 5'd0)};

        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.int_ack    = 1'b0;
        bus.frame_data = '0;
        bus.chan_en    = 3'b000;

        // Reset held while start toggles.
        repeat (4) begin
            tick();
            bus.start      = ~bus.start;
            bus.chan_en    = 3'b111;
            bus.frame_data = FB'($urandom);
        end
        tick();
        bus.start = 1'b0;
        check("reset_outs", 32'(outs()), 32'(IDLE_V));
        check("reset_fsm", 32'(bus.fsm_state), 32'd0);
        nReset = 1'b1;
        repeat (5) tick();
        check("post_reset_outs", 32'(outs()), 32'(IDLE_V));

        // Alternating-bit frame on channel 0, checked cycle by cycle.
        send_frame(26'h2AAAAAA, 3'b001, 0);
        for (int i = 0; i < 15; i++) begin
            go_to(tbl[i].rel);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].v));
        end
        ack("frame1");

        // Start together with abort while idle must not launch a frame.
        bus.frame_data = FB'($urandom);
        bus.chan_en    = 3'b111;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        check("idle_start_abort", 32'(outs()), 32'(IDLE_V));

        // All three channels, last bit is the only one.
        send_frame(26'h0000001, 3'b111, 0);
        go_to(25 * P_PERIOD + 1);
        check("multi_last_bit", 32'(outs()), 32'({2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 5'd0}));
        wait_done("multi");
        for (int ch = 0; ch < 3; ch++) check($sformatf("rx_word%0d", ch), 32'(rx[ch]), 32'h0000001);
        ack("multi");

        // Random frame; inputs change mid-frame and a second start arrives while busy.
        d = FB'($urandom);
        m = 3'($urandom_range(1, 7));
        send_frame(d, m, 0);
        bus.frame_data = ~d;
        bus.chan_en    = ~m;
        go_to(P_PERIOD + 10);
        bus.frame_data = d ^ FB'($urandom_range(1, 1000));
        bus.chan_en    = 3'b111;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("busy_start");
        ack("busy_start");

        // Abort inside the bit-23 pulse, then restart on the very next cycle.
        send_frame(FB'($urandom), 3'b010, 2 * P_PERIOD + 3);
        go_to(2 * P_PERIOD + 3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_outs", 32'(outs()), 32'(IDLE_V));
        check("abort_fsm", 32'(bus.fsm_state), 32'd0);
        send_frame(FB'($urandom), 3'b100, 0);
        check("restart_busy", {31'd0, bus.busy}, 32'd1);

        // int_ack coinciding with completion loses; one cycle later it clears.
        go_to(FRAME_LEN);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check("ack_same_cycle", {30'd0, bus.busy, bus.done_n}, 32'd0);
        ack("ack_late");

        bus.frame_data = FB'($urandom);
        bus.chan_en    = 3'b000;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (P_PERIOD) tick();
        check("no_chan_start", 32'(outs()), 32'(IDLE_V));

        // Asynchronous reset in the middle of a frame.
        send_frame(FB'($urandom), 3'b111, 30);
        go_to(30);
        nReset = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'(IDLE_V));
        tick();
        nReset = 1'b1;
        repeat (2 * P_PERIOD) tick();
        check("after_reset_idle", 32'(outs()), 32'(IDLE_V));

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wiegand_tx_ctrl.md
Name: wiegand_tx_ctrl

Overview:
- Wiegand output controller for the access-control CPLD.
- Takes a 26-bit frame and a channel-enable mask from the ARM bus register file, then serializes the frame MSB-first onto up to three Wiegand output ports with standard pulse and period timing derived from the 1 MHz clk.
- Raises an active-low completion interrupt that is ANDed into the shared eint11 line.
- Sequences the wil_out0/1/2 datapath and guarantees an inter-frame gap so downstream readers never merge frames.

Parameters:
- FRAME_BITS, 26: bits per frame (index FRAME_BITS-1 sent first).
- PULSE_CYC, 100: clk cycles the data line is held low per bit (100 us at 1 MHz).
- PERIOD_CYC, 2000: clk cycles per bit slot, pulse included. Constraints: PULSE_CYC < PERIOD_CYC <= 65535.
- GAP_CYC, 10000: clk cycles of idle-high after the last bit before completion (must exceed the receiver's 5 ms timeout).

Ports:
- clk, input, 1: 1 MHz system clock.
- nReset, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle request to send; sampled on clk rising edge.
- abort, input, 1: one-cycle request to cancel the frame in progress.
- frame_data, input, 26: frame to send, bit 25 first.
- chan_en, input, 3: bit n enables wil_out{n}.
- int_ack, input, 1: one-cycle pulse that clears done_n.
- busy, output, 1: high while a frame or its gap is in progress.
- done_n, output, 1: active-low completion interrupt.
- bit_idx, output, 5: index of the bit currently on the wire (25..0); 0 when idle.
- wil_out0, output, 2: channel 0 lines; [0]=D0, [1]=D1; idle 2'b11.
- wil_out1, output, 2: channel 1, same encoding.
- wil_out2, output, 2: channel 2, same encoding.

Behaviour:
- All outputs are registered.
- Reset values: wil_out0/1/2=2'b11, busy=0, done_n=1, bit_idx=0, FSM=IDLE, internal 16-bit cycle counter=0.
- FSM states: IDLE, PULSE, SPACE, GAP.
- IDLE:
  - On start=1, abort=0 and chan_en!=0 at edge T: latch frame_data into the shift register and chan_en into the mask, set bit_idx=25, clear done_n to 1, go to PULSE.
  - From cycle T+1: busy=1 and the enabled channels drive the bit low.
  - start with chan_en==0 is ignored: no busy, no done.
- PULSE:
  - Lasts PULSE_CYC cycles.
  - Current bit 0: enabled channels drive 2'b10 (D0 low).
  - Current bit 1: enabled channels drive 2'b01 (D1 low).
  - Then go to SPACE.
- SPACE:
  - Lasts PERIOD_CYC-PULSE_CYC cycles; all lines 2'b11.
  - At the end: if bit_idx!=0, decrement bit_idx, shift the register, and go to PULSE. Otherwise go to GAP.
- GAP:
  - Lasts GAP_CYC cycles; lines 2'b11, busy=1.
  - At the end: go to IDLE, set busy=0 and done_n=0 in the same cycle, set bit_idx=0.
- Frame timing with defaults, start at edge T:
  - Bit k low from T+1+(25-k)*2000 for 100 cycles.
  - busy falls and done_n falls at T+62001.
- Disabled channels hold 2'b11 for the whole frame. The mask and data are frozen at latch, so changes to frame_data/chan_en mid-frame have no effect.
- Lines are never both low: 2'b00 is illegal on any channel in any state.
- start while busy=1 is ignored; no queuing.
- abort:
  - In any non-IDLE state: next cycle lines=2'b11, busy=0, bit_idx=0, FSM=IDLE. done_n is not asserted.
  - Takes priority over start in the same cycle.
  - In IDLE it is a no-op.
- done_n: held low until int_ack or a new accepted start. If the set condition and int_ack occur in the same cycle, set wins (done_n=0).
- Reset asserted mid-frame: outputs return to reset values asynchronously; no partial frame resumes after reset release.
- The cycle counter reloads at every state entry; no wrap occurs within legal parameter ranges.

Test Plan:
- Reset check: hold nReset low, toggle start -> all wil_out=2'b11, busy=0, done_n=1, bit_idx=0; after release, outputs unchanged until start.
- Full frame: frame_data=26'h2AAAAAA, chan_en=3'b001, start at T -> wil_out0:
  - bit 25=1 gives 2'b01 on T+1..T+100, then 2'b11 to T+2000;
  - bit 24=0 gives 2'b10 from T+2001;
  - wil_out1/2 stay 2'b11;
  - busy falls and done_n=0 at T+62001.
- Multi-channel: frame 26'h0000001, chan_en=3'b111 -> all three channels identical:
  - bits 25..1 appear as D0 pulses;
  - final bit appears as D1 pulse at T+50001;
  - a loopback receiver decoder captures 26'h0000001.
- Start while busy: second start at T+3000 with different data -> ignored; wire pattern matches the first frame; a single done_n.
- Abort: abort at T+4050 (inside bit 23 pulse) -> lines 2'b11 at T+4051, busy=0, done_n stays 1; a new start is accepted the next cycle.
- Interrupt handshake: int_ack in the cycle done_n is set -> done_n=0 stays; int_ack one cycle later -> done_n=1; start with chan_en=0 -> no activity.
